// File: rtl/pingpong_bank_ctrl_pkg.sv
// Shared definitions for the ping-pong bank controller: bank and read-sequencer
// state encodings plus the bank-index to one-hot select helper.
package pingpong_bank_ctrl_pkg;

  // The bankRAM always has exactly two banks
  localparam int NO_BANKS = 2;

  typedef logic [NO_BANKS-1:0] bank_mask_t;

  // Lifecycle of a single bank: FREE -> FILLING -> FULL -> READING -> FREE
  typedef enum logic [1:0] {
    FREE    = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    READING = 2'd3
  } bank_state_e;

  // Read sequencer: STREAM issues addresses, DRAIN covers the last RAM data cycle
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } rd_state_e;

  // Converts a bank index into its one-hot bank select
  function automatic bank_mask_t bankOneHot(input logic bankIdx);
    return bankIdx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/pingpong_bank_ctrl_rd_seq.sv
// Read sequencer for the ping-pong controller. Streams one complete frame out of
// the read bank, delays the issue flag by the RAM read latency, and tells the
// parent when the bank can be released.
module pingpong_rd_seq
  import pingpong_bank_ctrl_pkg::*;
#(
  parameter int address_width = 12,
  parameter int frame_len     = 4096
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_frame_start,
  input  logic                     i_frame_valid,
  input  logic                     i_rd_bank,
  output logic                     o_accept,
  output logic                     o_release,
  output bank_mask_t               o_rd_bank_select,
  output logic [address_width-1:0] o_rd_address,
  output logic                     o_rd_data_valid,
  output logic                     o_rd_last,
  output logic                     o_busy
);

  localparam logic [address_width-1:0] RD_LAST = address_width'(frame_len - 1);

  rd_state_e                r_state;
  bank_mask_t               r_rdBankSelect;
  logic [address_width-1:0] r_rdAddress;
  logic                     r_dataValid;
  logic                     r_last;
  logic                     r_busy;
  logic                     w_accept;

  // A frame is only taken when idle and one is actually waiting
  assign w_accept  = (r_state == IDLE) && i_frame_start && i_frame_valid;
  assign o_accept  = w_accept;
  // The bank is handed back on the edge that leaves DRAIN
  assign o_release = (r_state == DRAIN);

  assign o_rd_bank_select = r_rdBankSelect;
  assign o_rd_address     = r_rdAddress;
  assign o_rd_data_valid  = r_dataValid;
  assign o_rd_last        = r_last;
  assign o_busy           = r_busy;

  // Read FSM with address counter and one-cycle valid/last delay matching RAM latency
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_rdBankSelect <= '0;
      r_rdAddress    <= '0;
      r_dataValid    <= 1'b0;
      r_last         <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_dataValid <= (r_state == STREAM);
      r_last      <= (r_state == STREAM) && (r_rdAddress == RD_LAST);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state        <= STREAM;
            r_rdBankSelect <= bankOneHot(i_rd_bank);
            r_rdAddress    <= '0;
            r_busy         <= 1'b1;
          end
        end
        STREAM: begin
          if (r_rdAddress == RD_LAST) begin
            r_state     <= DRAIN;
            r_rdAddress <= '0;
          end else begin
            r_rdAddress <= r_rdAddress + address_width'(1);
          end
        end
        DRAIN: begin
          r_state        <= IDLE;
          r_rdBankSelect <= '0;
          r_busy         <= 1'b0;
        end
        default: begin
          r_state        <= IDLE;
          r_rdBankSelect <= '0;
          r_busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pingpong_bank_ctrl.sv
// Ping-pong controller for the two-bank capture memory. Fills one bank with a
// frame of samples while the other bank's completed frame is streamed to the
// consumer; drops and counts samples when both banks are occupied.
module pingpong_bank_ctrl
  import pingpong_bank_ctrl_pkg::*;
#(
  parameter int address_width = 12,
  parameter int frame_len     = 4096,
  parameter int cnt_width     = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_sample_valid,
  output bank_mask_t               o_wr_bank_select,
  output bank_mask_t               o_wr_en,
  output logic [address_width-1:0] o_wr_address,
  output logic                     o_frame_valid,
  input  logic                     i_frame_start,
  output bank_mask_t               o_rd_bank_select,
  output logic [address_width-1:0] o_rd_address,
  output logic                     o_rd_data_valid,
  output logic                     o_rd_last,
  output logic                     o_overflow,
  output logic [cnt_width-1:0]     o_drop_count,
  output logic                     o_busy
);

  localparam logic [address_width-1:0] WR_LAST = address_width'(frame_len - 1);

  bank_state_e              r_bankState [NO_BANKS];
  logic                     r_wrBank;
  logic [address_width-1:0] r_wrAddress;
  logic [cnt_width-1:0]     r_dropCount;

  logic w_rdBank;
  logic w_filling;
  logic w_accept;
  logic w_wrDone;
  logic w_drop;
  logic w_release;
  logic w_startAccept;
  logic w_otherFree;
  logic w_stallExit;
  logic w_frameValid;

  // The read side always works on the bank that is not being written
  assign w_rdBank     = ~r_wrBank;
  assign w_filling    = (r_bankState[r_wrBank] == FILLING);
  assign w_accept     = i_sample_valid && w_filling;
  assign w_wrDone     = w_accept && (r_wrAddress == WR_LAST);
  assign w_drop       = i_sample_valid && !w_filling;
  assign w_frameValid = (r_bankState[w_rdBank] == FULL);
  // A bank being released this cycle counts as free so a completing frame swaps without a stall
  assign w_otherFree  = (r_bankState[w_rdBank] == FREE) || w_release;
  assign w_stallExit  = !w_filling && (r_bankState[w_rdBank] == FREE);

  assign o_wr_bank_select = bankOneHot(r_wrBank);
  assign o_wr_en          = w_accept ? bankOneHot(r_wrBank) : 2'b00;
  assign o_wr_address     = r_wrAddress;
  assign o_frame_valid    = w_frameValid;
  assign o_overflow       = w_drop;
  assign o_drop_count     = r_dropCount;

  pingpong_rd_seq #(
    .address_width (address_width),
    .frame_len     (frame_len)
  ) u_rdSeq (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_frame_start    (i_frame_start),
    .i_frame_valid    (w_frameValid),
    .i_rd_bank        (w_rdBank),
    .o_accept         (w_startAccept),
    .o_release        (w_release),
    .o_rd_bank_select (o_rd_bank_select),
    .o_rd_address     (o_rd_address),
    .o_rd_data_valid  (o_rd_data_valid),
    .o_rd_last        (o_rd_last),
    .o_busy           (o_busy)
  );

  // Bank ownership and write counter; later assignments deliberately override earlier ones
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_bankState[0] <= FILLING;
      r_bankState[1] <= FREE;
      r_wrBank       <= 1'b0;
      r_wrAddress    <= '0;
    end else begin
      if (w_release) begin
        r_bankState[w_rdBank] <= FREE;
      end
      if (w_startAccept) begin
        r_bankState[w_rdBank] <= READING;
      end
      if (w_wrDone) begin
        r_bankState[r_wrBank] <= FULL;
        r_wrAddress           <= '0;
        if (w_otherFree) begin
          r_bankState[w_rdBank] <= FILLING;
          r_wrBank              <= ~r_wrBank;
        end
      end else if (w_accept) begin
        r_wrAddress <= r_wrAddress + address_width'(1);
      end else if (w_stallExit) begin
        r_bankState[w_rdBank] <= FILLING;
        r_wrBank              <= ~r_wrBank;
        r_wrAddress           <= '0;
      end
    end
  end

  // Saturating count of samples dropped while no bank can accept them
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dropCount <= '0;
    end else if (w_drop && (r_dropCount != '1)) begin
      r_dropCount <= r_dropCount + cnt_width'(1);
    end
  end

endmodule
